// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the async FIFO read-side consumer.
//   occ_state_e    : skid buffer occupancy encoding (EMPTY/ONE/TWO)
//   SKID_DEPTH     : entries in the skid buffer
//   beat_cnt_width : width of the burst beat counters (clog2, minimum 1)
// -----------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

  localparam int SKID_DEPTH = 2;

  function automatic int beat_cnt_width(input int burst_len);
    return (burst_len <= 2) ? 1 : $clog2(burst_len);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// -----------------------------------------------------------------------------
// fifo_skid_buf
// Two-entry circular buffer of {last,data} words that absorbs the one-cycle
// read latency of the FIFO RAM.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_word at the tail (caller guarantees room)
//   push_word   : {last, data} to store
//   pop         : retire the head entry (caller guarantees occ != EMPTY)
//   clear       : synchronous discard of all entries, wins over push/pop
//   head_word   : {last, data} at the head
//   occ         : occupancy state, also the observable FSM state
// -----------------------------------------------------------------------------
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int WORD_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WORD_WIDTH-1:0] push_word,
  input  logic                  pop,
  input  logic                  clear,
  output logic [WORD_WIDTH-1:0] head_word,
  output occ_state_e            occ
);

  logic [WORD_WIDTH-1:0] mem [SKID_DEPTH];
  logic                  head_ptr;
  logic                  tail_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      occ      <= EMPTY;
    end else if (clear) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      occ      <= EMPTY;
    end else begin
      if (push) begin
        mem[tail_ptr] <= push_word;
        tail_ptr      <= ~tail_ptr;
      end
      if (pop) head_ptr <= ~head_ptr;
      // Simultaneous push and pop leaves the occupancy unchanged.
      unique case ({push, pop})
        2'b10:   occ <= (occ == EMPTY) ? ONE : TWO;
        2'b01:   occ <= (occ == TWO) ? ONE : EMPTY;
        default: occ <= occ;
      endcase
    end
  end

  assign head_word = mem[head_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-domain consumer for the async FIFO. Pops the FIFO read port, whose data
// returns one cycle after the pop, buffers words in a 2-entry skid buffer and
// presents them as a burst-framed valid/ready stream.
//
// Handshake: a word transfers on every rd_clk edge where out_valid and
// out_ready are both 1; out_valid never drops and out_data/out_last never
// change while out_valid=1 and out_ready=0 (except on flush or reset).
//
// Ports:
//   rd_clk, rd_rst_n : clock, asynchronous active-low reset
//   fifo_rd_en       : pop request (combinational, depends on out_ready)
//   fifo_rd_data     : FIFO data, valid the cycle after fifo_rd_en
//   fifo_empty       : FIFO empty flag
//   flush            : synchronous discard of buffered and in-flight words
//   out_valid/out_ready/out_data/out_last : downstream stream
//   busy             : buffer non-empty or a pop is in flight
//   dbg_occ          : occupancy FSM state
//   word_cnt, burst_cnt : delivered words / bursts, only when the macro
//                      FIFO_RD_STREAM_STAT_EN is defined
// -----------------------------------------------------------------------------
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [1:0]            dbg_occ
`ifdef FIFO_RD_STREAM_STAT_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  burst_cnt
`endif
);

  localparam int BW = beat_cnt_width(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  occ_state_e          occ;
  logic                started;
  logic                inflight;
  logic                pop;
  logic                capture;
  logic                cap_last;
  logic [2:0]          level;
  logic [BW-1:0]       beat_cnt;
  logic [BW-1:0]       cap_cnt;
  logic [DATA_WIDTH:0] head_word;

  assign pop     = out_valid & out_ready;
  assign capture = inflight & ~flush;

  // Entries committed after this cycle: stored plus in flight minus leaving.
  assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  // started keeps the pop request low while reset is asserted.
  assign fifo_rd_en = started & ~fifo_empty & ~flush & (level < 3'd2);

  // The last flag is fixed when the word enters the buffer so the head
  // entry carries its own framing regardless of downstream stalls.
  assign cap_last = (cap_cnt == LAST_BEAT);

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      started  <= 1'b0;
      inflight <= 1'b0;
      cap_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      started  <= 1'b1;
      inflight <= fifo_rd_en;
      if (flush) begin
        cap_cnt  <= '0;
        beat_cnt <= '0;
      end else begin
        if (capture) cap_cnt <= cap_last ? '0 : cap_cnt + 1'b1;
        if (pop)     beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      end
    end
  end

  fifo_skid_buf #(
    .WORD_WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .push      (capture),
    .push_word ({cap_last, fifo_rd_data}),
    .pop       (pop),
    .clear     (flush),
    .head_word (head_word),
    .occ       (occ)
  );

  assign out_valid = (occ != EMPTY);
  assign out_last  = head_word[DATA_WIDTH];
  assign out_data  = head_word[DATA_WIDTH-1:0];
  assign busy      = (occ != EMPTY) | inflight;
  assign dbg_occ   = occ;

`ifdef FIFO_RD_STREAM_STAT_EN
  // Statistics survive flush; only reset clears them.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      word_cnt  <= '0;
      burst_cnt <= '0;
    end else if (pop) begin
      word_cnt <= word_cnt + 1'b1;
      if (out_last) burst_cnt <= burst_cnt + 1'b1;
    end
  end
`endif

  a_params: assert property (@(posedge rd_clk)
    (BURST_LEN >= 1) && (BURST_LEN <= 256) && (CNT_WIDTH >= 1));

  a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    !(capture && !pop && (occ == TWO)));

  a_occ_bound: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    (({1'b0, occ} + {2'b00, inflight}) <= 3'd2));

  // Delivery-side beat count must agree with the capture-side last flag.
  a_last_align: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    out_valid |-> (out_last == (beat_cnt == LAST_BEAT)));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Directed bench for fifo_rd_stream with a registered-read FIFO model and a
// word scoreboard. Define FIFO_RD_STREAM_STAT_EN to also check the counters.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

  localparam int DW = 4;
  localparam int BL = 4;
  localparam int CW = 16;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_empty;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic [1:0]    dbg_occ;
`ifdef FIFO_RD_STREAM_STAT_EN
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] burst_cnt;
`endif

  fifo_rd_stream #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL),
    .CNT_WIDTH (CW)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .dbg_occ      (dbg_occ)
`ifdef FIFO_RD_STREAM_STAT_EN
    ,
    .word_cnt     (word_cnt),
    .burst_cnt    (burst_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 rd_clk = ~rd_clk;

  // ---------------- bench state ----------------
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] fifo_q[$];   // words still inside the FIFO model
  logic [DW-1:0] exp_q[$];    // words popped from the FIFO, awaiting delivery
  int            dlv_cnt   = 0;  // model beat position of the next delivery
  int            delivered = 0;
  int            issued    = 0;
  int            exp_words  = 0;
  int            exp_bursts = 0;
  logic          s_en;
  logic          s_pop;
  logic          prev_stall = 1'b0;
  logic [DW:0]   prev_word  = '0;
  int            d0;
  int            i0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, update the FIFO model just
  // after the rising edge (registered read data and registered empty flag).
  task automatic step();
    logic [DW-1:0] w;
    logic          l;
    @(negedge rd_clk);
    s_en  = fifo_rd_en;
    s_pop = out_valid & out_ready;
    if (prev_stall && out_valid) check("stall_hold", {27'd0, out_last, out_data}, {27'd0, prev_word});
    prev_stall = out_valid & ~out_ready;
    prev_word  = {out_last, out_data};
    if (s_pop) begin
      l = (dlv_cnt == BL - 1);
      check("sb_has_word", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("word_data", 32'(out_data), 32'(w));
        check("word_last", 32'(out_last), 32'(l));
      end
      dlv_cnt = (dlv_cnt == BL - 1) ? 0 : dlv_cnt + 1;
      delivered++;
      exp_words++;
      if (l) exp_bursts++;
    end
    if (s_en) begin
      issued++;
      check("pop_while_empty", 32'(fifo_empty), 32'd0);
      if (fifo_q.size() != 0) exp_q.push_back(fifo_q[0]);
    end
    if (flush) begin
      exp_q.delete();
      dlv_cnt = 0;
    end
    @(posedge rd_clk);
    #1;
    if (s_en && fifo_q.size() != 0) fifo_rd_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < budget), 32'd1);
    #1;
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic load(input int first, input int count);
    for (int k = 0; k < count; k++) fifo_q.push_back(DW'(first + k));
  endtask

`ifdef FIFO_RD_STREAM_STAT_EN
  task automatic check_stats(input string tag);
    check({tag, "_word_cnt"}, 32'(word_cnt), 32'(exp_words));
    check({tag, "_burst_cnt"}, 32'(burst_cnt), 32'(exp_bursts));
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rd_rst_n     = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    repeat (2) step();
    #1;
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rd_rst_n = 1'b1;
    repeat (2) step();

    // T1: latency, full throughput, framing on words 4 and 8
    load(1, 8);
    out_ready = 1'b1;
    step();
    #1;
    check("t1_en_c0", 32'(fifo_rd_en), 32'd1);
    check("t1_valid_c0", 32'(out_valid), 32'd0);
    step();
    #1;
    check("t1_valid_c1", 32'(out_valid), 32'd0);
    check("t1_busy_c1", 32'(busy), 32'd1);
    step();
    #1;
    check("t1_valid_c2", 32'(out_valid), 32'd1);
    check("t1_data_c2", 32'(out_data), 32'd1);
    d0 = delivered;
    repeat (8) step();
    check("t1_throughput", 32'(delivered - d0), 32'd8);
    run_idle("t1", 20);

    // T2: stalled consumer, only two pops outstanding
    out_ready = 1'b0;
    load(1, 5);
    step();
    i0 = issued;
    repeat (5) step();
    check("t2_issued", 32'(issued - i0), 32'd2);
    #1;
    check("t2_occ", 32'(dbg_occ), 32'd2);
    check("t2_rd_en", 32'(fifo_rd_en), 32'd0);
    check("t2_data", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    d0 = delivered;
    repeat (5) step();
    check("t2_no_gap", 32'(delivered - d0), 32'd5);
    run_idle("t2", 20);

    // T3: toggling ready
    load(3, 12);
    d0 = delivered;
    for (int k = 0; k < 24; k++) begin
      out_ready = (k % 2 == 0);
      step();
    end
    out_ready = 1'b1;
    run_idle("t3", 40);
    check("t3_count", 32'(delivered - d0), 32'd12);

    // T4: flush with one word buffered and one in flight
    out_ready = 1'b0;
    load(6, 10);
    repeat (3) step();
    #1;
    check("t4_occ_one", 32'(dbg_occ), 32'd1);
    check("t4_busy_pre", 32'(busy), 32'd1);
    flush = 1'b1;
    #1;
    check("t4_flush_rd_en", 32'(fifo_rd_en), 32'd0);
    step();
    flush = 1'b0;
    #1;
    check("t4_valid_post", 32'(out_valid), 32'd0);
    check("t4_busy_post", 32'(busy), 32'd0);
    check("t4_occ_post", 32'(dbg_occ), 32'd0);
    out_ready = 1'b1;
    d0 = delivered;
    run_idle("t4", 30);
    check("t4_count", 32'(delivered - d0), 32'd8);

    // T5: FIFO becomes non-empty while flush is held
    flush = 1'b1;
    load(9, 3);
    repeat (3) begin
      step();
      #1;
      check("t5_rd_en_flush", 32'(fifo_rd_en), 32'd0);
    end
    flush = 1'b0;
    #1;
    check("t5_rd_en_release", 32'(fifo_rd_en), 32'd1);
    run_idle("t5", 20);
`ifdef FIFO_RD_STREAM_STAT_EN
    check_stats("t5");
`endif

    // T6: reset mid-burst with the buffer full
    load(1, 10);
    out_ready = 1'b1;
    step();
    d0 = delivered;
    repeat (4) step();
    out_ready = 1'b0;
    repeat (2) step();
    check("t6_two_words", 32'(delivered - d0), 32'd2);
    #1;
    check("t6_occ_full", 32'(dbg_occ), 32'd2);
    #2;
    rd_rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_data", 32'(out_data), 32'd0);
    check("t6_rst_last", 32'(out_last), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    fifo_q.delete();
    exp_q.delete();
    dlv_cnt    = 0;
    exp_words  = 0;
    exp_bursts = 0;
    prev_stall = 1'b0;
    step();
    rd_rst_n = 1'b1;
    step();
    load(1, 6);
    out_ready = 1'b1;
    d0 = delivered;
    run_idle("t6", 30);
    check("t6_count", 32'(delivered - d0), 32'd6);
`ifdef FIFO_RD_STREAM_STAT_EN
    check_stats("t6");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
